// File: rtl/ws2812_chain_tx.sv
// rtl/ws2812_chain_tx.sv - WS2812B chain driver: pixel stream in, NRZ bit waveform plus latch period out
// A one-word hold register is refilled while the shift register is still sending.
module ws2812_chain_tx #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int NUM_LEDS  = 8,
   parameter int CHANNELS  = 3,
   parameter int T0H_NS    = 400,
   parameter int T1H_NS    = 800,
   parameter int TBIT_NS   = 1250,
   parameter int TRESET_NS = 300_000,
   parameter int INVERT    = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [8*CHANNELS-1:0]   pix_data,
   input  logic                    pix_valid,
   output logic                    pix_ready,
   output logic                    busy,
   output logic                    done,
   output logic                    underrun,
   output logic                    dout
);

   localparam int MHZ        = CLK_HZ / 1_000_000;
   localparam int T0H_CYC    = (T0H_NS * MHZ) / 1000;
   localparam int T1H_CYC    = (T1H_NS * MHZ) / 1000;
   localparam int TBIT_CYC   = (TBIT_NS * MHZ) / 1000;
   localparam int TRESET_CYC = (TRESET_NS * MHZ) / 1000;
   localparam int NBITS      = 8 * CHANNELS;
   localparam int CW         = $clog2(TBIT_CYC);
   localparam int BW         = $clog2(NBITS);
   localparam int LW         = $clog2(TRESET_CYC + 1);
   localparam int NW         = $clog2(NUM_LEDS + 1);

   localparam logic [CW-1:0] T0H_W     = CW'(T0H_CYC);
   localparam logic [CW-1:0] T1H_W     = CW'(T1H_CYC);
   localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT_CYC - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);
   localparam logic [LW-1:0] LAT_LAST  = LW'(TRESET_CYC - 1);
   localparam logic [NW-1:0] NUM_W     = NW'(NUM_LEDS);
   localparam logic          INV_L     = (INVERT != 0);

   if (!(T0H_CYC >= 1 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC && TRESET_CYC >= 1)) begin : g_bad_timing
      $error("ws2812_chain_tx: derived timing must satisfy 1 <= T0H < T1H < TBIT and TRESET >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_LATCH} state_t;

   state_t           state_q, state_d;
   logic [NBITS-1:0] shift_q, shift_d;
   logic [NBITS-1:0] hold_q, hold_d;
   logic             hold_valid_q, hold_valid_d;
   logic [CW-1:0]    cyc_q, cyc_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [LW-1:0]    latch_q, latch_d;
   logic [NW-1:0]    acc_q, acc_d;
   logic [NW-1:0]    loaded_q, loaded_d;
   logic             dout_q, dout_d;
   logic             done_q, done_d;
   logic             underrun_q, underrun_d;
   logic             load, xfer, active;
   logic [CW-1:0]    high_len;

   assign busy      = (state_q != S_IDLE);
   assign pix_ready = busy && !hold_valid_q && (acc_q < NUM_W);
   assign xfer      = pix_valid && pix_ready;
   assign done      = done_q;
   assign underrun  = underrun_q;
   assign dout      = dout_q;

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      cyc_d        = cyc_q;
      bit_d        = bit_q;
      latch_d      = latch_q;
      acc_d        = acc_q;
      loaded_d     = loaded_q;
      done_d       = 1'b0;
      underrun_d   = 1'b0;
      load         = 1'b0;
      active       = 1'b0;
      high_len     = '0;

      case (state_q)
         S_IDLE: begin
            // the cycle carrying done still counts as the end of the old frame
            if (start && !done_q) begin
               state_d  = S_FETCH;
               acc_d    = '0;
               loaded_d = '0;
            end
         end
         S_FETCH: begin
            if (hold_valid_q) load = 1'b1;
         end
         S_SEND: begin
            if (cyc_q == TBIT_LAST) begin
               cyc_d = '0;
               if (bit_q == BIT_LAST) begin
                  if (loaded_q == NUM_W) begin
                     state_d = S_LATCH;
                     latch_d = '0;
                  end else if (hold_valid_q) begin
                     load = 1'b1;
                  end else begin
                     underrun_d = 1'b1;
                     state_d    = S_FETCH;
                  end
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = {shift_q[NBITS-2:0], 1'b0};
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_LATCH: begin
            if (latch_q == LAT_LAST) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               latch_d = latch_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         state_d      = S_SEND;
         shift_d      = hold_q;
         cyc_d        = '0;
         bit_d        = '0;
         loaded_d     = loaded_q + 1'b1;
         hold_valid_d = 1'b0;
      end
      // xfer needs an empty hold and load needs a full one, so they never collide
      if (xfer) begin
         hold_d       = pix_data;
         hold_valid_d = 1'b1;
         acc_d        = acc_q + 1'b1;
      end

      high_len = shift_d[NBITS-1] ? T1H_W : T0H_W;
      active   = (state_d == S_SEND) && (cyc_d < high_len);
      dout_d   = active ^ INV_L;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         shift_q      <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         cyc_q        <= '0;
         bit_q        <= '0;
         latch_q      <= '0;
         acc_q        <= '0;
         loaded_q     <= '0;
         dout_q       <= INV_L;
         done_q       <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         cyc_q        <= cyc_d;
         bit_q        <= bit_d;
         latch_q      <= latch_d;
         acc_q        <= acc_d;
         loaded_q     <= loaded_d;
         dout_q       <= dout_d;
         done_q       <= done_d;
         underrun_q   <= underrun_d;
      end
   end

endmodule

// File: tb/tb_ws2812_chain_tx.sv
// tb/tb_ws2812_chain_tx.sv - bench for ws2812_chain_tx: waveform-queue model compared every cycle
// Two instances: GRB chain of 2 LEDs, and an inverted single GRBW LED.
module tb_ws2812_chain_tx;

   localparam int TBIT = (1250 * 50) / 1000;
   localparam int T0H  = (400 * 50) / 1000;
   localparam int T1H  = (800 * 50) / 1000;

   int nl[2]   = '{2, 1};
   int nb[2]   = '{24, 32};
   bit inv[2]  = '{1'b0, 1'b1};
   int trst[2] = '{(20_000 * 50) / 1000, (10_000 * 50) / 1000};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  st = '0;
   logic [1:0]  vl = '0;
   logic [31:0] data_i [2];
   logic [1:0]  ready_o, busy_o, done_o, und_o, dout_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   bit          m_busy[2], m_done[2], m_und[2], m_hv[2];
   logic [31:0] m_hold[2];
   int          m_acc[2], m_started[2], m_latch[2], m_head[2], m_tail[2];
   bit          m_wave[2][0:2047];

   int act_cnt[2], rise_cnt[2], done_cnt[2], und_cnt[2], xfer_cnt[2], first_act[2], done_at[2];
   bit prev_lvl[2];

   ws2812_chain_tx #(.CLK_HZ(50_000_000), .NUM_LEDS(2), .CHANNELS(3), .TRESET_NS(20_000)) u0 (
      .clk(clk), .rst(rst), .start(st[0]), .pix_data(data_i[0][23:0]), .pix_valid(vl[0]),
      .pix_ready(ready_o[0]), .busy(busy_o[0]), .done(done_o[0]), .underrun(und_o[0]), .dout(dout_o[0]));

   ws2812_chain_tx #(.CLK_HZ(50_000_000), .NUM_LEDS(1), .CHANNELS(4), .TRESET_NS(10_000), .INVERT(1)) u1 (
      .clk(clk), .rst(rst), .start(st[1]), .pix_data(data_i[1]), .pix_valid(vl[1]),
      .pix_ready(ready_o[1]), .busy(busy_o[1]), .done(done_o[1]), .underrun(und_o[1]), .dout(dout_o[1]));

   always #5 clk = ~clk;

   function automatic bit m_ready(int id);
      return m_busy[id] && !m_hv[id] && (m_acc[id] < nl[id]);
   endfunction

   task automatic push_word(input int id);
      int hi;
      m_head[id] = 0;
      m_tail[id] = 0;
      for (int b = nb[id] - 1; b >= 0; b--) begin
         hi = m_hold[id][b] ? T1H : T0H;
         for (int t = 0; t < TBIT; t++) begin
            m_wave[id][m_tail[id]] = (t < hi);
            m_tail[id]++;
         end
      end
      m_started[id]++;
      m_hv[id] = 1'b0;
   endtask

   // one clock edge of the model; m_wave[head] is the level shown after the edge
   task automatic model_step(input int id);
      bit xfer, prev_done, ended;
      if (rst) begin
         m_busy[id] = 0; m_done[id] = 0; m_und[id] = 0; m_hv[id] = 0;
         m_acc[id] = 0; m_started[id] = 0; m_latch[id] = 0; m_head[id] = 0; m_tail[id] = 0;
         return;
      end
      xfer      = vl[id] && m_ready(id);
      prev_done = m_done[id];
      m_done[id] = 0;
      m_und[id]  = 0;
      if (!m_busy[id]) begin
         if (st[id] && !prev_done) begin
            m_busy[id] = 1; m_acc[id] = 0; m_started[id] = 0; m_hv[id] = 0;
            m_latch[id] = 0; m_head[id] = 0; m_tail[id] = 0;
         end
      end else begin
         ended = 0;
         if (m_head[id] < m_tail[id]) begin
            m_head[id]++;
            ended = (m_head[id] == m_tail[id]);
         end else if (m_latch[id] > 0) begin
            m_latch[id]--;
            if (m_latch[id] == 0) begin
               m_done[id] = 1;
               m_busy[id] = 0;
            end
         end
         if (ended) begin
            if (m_started[id] == nl[id]) m_latch[id] = trst[id];
            else if (m_hv[id]) push_word(id);
            else m_und[id] = 1;
         end else if (m_head[id] == m_tail[id] && m_latch[id] == 0 && m_busy[id] && m_hv[id]) begin
            push_word(id);
         end
         if (xfer) begin
            m_hv[id]   = 1;
            m_hold[id] = data_i[id];
            m_acc[id]++;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      for (int id = 0; id < 2; id++)
         if (!rst && vl[id] && ready_o[id]) xfer_cnt[id]++;
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         for (int id = 0; id < 2; id++) begin
            logic [4:0] exp_v, act_v;
            bit lvl;
            exp_v = {((m_head[id] < m_tail[id]) ? m_wave[id][m_head[id]] : 1'b0) ^ inv[id],
                     m_busy[id], m_ready(id), m_done[id], m_und[id]};
            act_v = {dout_o[id], busy_o[id], ready_o[id], done_o[id], und_o[id]};
            checks++;
            if (act_v !== exp_v) begin
               errors++;
               $display("FAIL cycle_cmp dut%0d cyc %0d dout/busy/ready/done/underrun got %b expected %b",
                        id, cyc, act_v, exp_v);
            end
            lvl = dout_o[id] ^ inv[id];
            if (lvl) act_cnt[id]++;
            if (lvl && !prev_lvl[id]) begin
               rise_cnt[id]++;
               if (first_act[id] < 0) first_act[id] = cyc;
            end
            if (done_o[id]) begin
               done_cnt[id]++;
               done_at[id] = cyc;
            end
            if (und_o[id]) und_cnt[id]++;
            prev_lvl[id] = lvl;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clr(input int id);
      act_cnt[id] = 0; rise_cnt[id] = 0; done_cnt[id] = 0; und_cnt[id] = 0;
      xfer_cnt[id] = 0; first_act[id] = -1; done_at[id] = -1;
   endtask

   task automatic pulse_start(input int id);
      st[id] = 1'b1;
      @(negedge clk);
      st[id] = 1'b0;
   endtask

   task automatic wait_xfers(input int id, input int target, input int limit);
      int k = 0;
      while (xfer_cnt[id] < target && k < limit) begin
         @(negedge clk);
         k++;
      end
      check("xfer_wait", xfer_cnt[id], target);
   endtask

   task automatic wait_done(input int id, input int limit);
      int k = 0;
      while (done_cnt[id] == 0 && k < limit) begin
         @(negedge clk);
         k++;
      end
      check("done_wait", done_cnt[id], 1);
   endtask

   initial begin
      data_i[0] = '0;
      data_i[1] = '0;
      clr(0);
      clr(1);
      @(negedge clk);
      chk_en = 1'b1;
      tick(2);
      rst = 1'b0;
      check("rst_dout0", dout_o[0], 0);
      check("rst_dout1", dout_o[1], 1);
      check("rst_busy", busy_o, 0);
      check("rst_ready", ready_o, 0);
      check("rst_done_und", {done_o, und_o}, 0);
      tick(3);

      // reference frame: FF0000 then 000001, valid held high
      clr(0);
      pulse_start(0);
      vl[0] = 1'b1;
      data_i[0] = 32'h00FF0000;
      wait_xfers(0, 1, 50);
      data_i[0] = 32'h00000001;
      wait_xfers(0, 2, 3000);
      vl[0] = 1'b0;
      wait_done(0, 20000);
      check("ref_active_cycles", act_cnt[0], 1140);
      check("ref_pulses", rise_cnt[0], 48);
      check("ref_frame_len", done_at[0] - first_act[0], 2976 + 1000);
      check("ref_underruns", und_cnt[0], 0);
      tick(2);
      check("ref_idle_after", dout_o[0], 0);

      // second word withheld until 100 cycles after the first word ends
      clr(0);
      pulse_start(0);
      vl[0] = 1'b1;
      data_i[0] = $urandom;
      wait_xfers(0, 1, 50);
      vl[0] = 1'b0;
      tick(24 * TBIT + 100);
      vl[0] = 1'b1;
      data_i[0] = $urandom;
      wait_xfers(0, 2, 50);
      vl[0] = 1'b0;
      wait_done(0, 20000);
      check("gap_underruns", und_cnt[0], 1);
      tick(2);

      // start pulses during SEND and during LATCH are ignored
      clr(0);
      pulse_start(0);
      vl[0] = 1'b1;
      data_i[0] = $urandom;
      wait_xfers(0, 2, 100);
      vl[0] = 1'b0;
      tick(100);
      pulse_start(0);
      tick(3100);
      pulse_start(0);
      wait_done(0, 20000);
      tick(50);
      check("stray_start_xfers", xfer_cnt[0], 2);
      check("stray_start_done", done_cnt[0], 1);
      check("stray_start_idle", busy_o[0], 0);

      // reset mid-bit of word 2, then a clean frame
      clr(0);
      pulse_start(0);
      vl[0] = 1'b1;
      data_i[0] = $urandom;
      wait_xfers(0, 2, 100);
      tick(24 * TBIT + 30);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vl[0] = 1'b0;
      check("midrst_outputs", {dout_o[0], busy_o[0], ready_o[0], done_o[0], und_o[0]}, 0);
      tick(200);
      check("midrst_no_done", done_cnt[0], 0);
      clr(0);
      pulse_start(0);
      vl[0] = 1'b1;
      data_i[0] = $urandom;
      wait_done(0, 20000);
      vl[0] = 1'b0;
      check("postrst_xfers", xfer_cnt[0], 2);
      tick(2);

      // start together with reset stays idle
      rst = 1'b1;
      st[0] = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      st[0] = 1'b0;
      check("start_rst_busy", busy_o[0], 0);
      tick(5);
      check("start_rst_idle", {busy_o[0], ready_o[0]}, 0);

      // randomized frames with random valid density and stray starts
      for (int f = 0; f < 5; f++) begin
         int p, k;
         p = (f == 0) ? 100 : (f == 1) ? 60 : (f == 2) ? 15 : int'($urandom_range(10, 100));
         clr(0);
         k = 0;
         while (done_cnt[0] == 0 && k < 20000) begin
            st[0] = (k == 0) || (busy_o[0] && $urandom_range(0, 149) == 0);
            vl[0] = ($urandom_range(0, 99) < p);
            data_i[0] = $urandom;
            @(negedge clk);
            k++;
         end
         st[0] = 1'b0;
         vl[0] = 1'b0;
         check("rand_done", done_cnt[0], 1);
         check("rand_xfers", xfer_cnt[0], 2);
         tick(3);
      end

      // inverted GRBW single LED, valid kept high through the frame
      clr(1);
      check("inv_idle_before", dout_o[1], 1);
      pulse_start(1);
      vl[1] = 1'b1;
      data_i[1] = 32'hA5A5A5A5;
      wait_done(1, 20000);
      vl[1] = 1'b0;
      check("inv_active_cycles", act_cnt[1], 16 * T1H + 16 * T0H);
      check("inv_pulses", rise_cnt[1], 32);
      check("inv_frame_len", done_at[1] - first_act[1], 32 * 62 + 500);
      check("inv_single_xfer", xfer_cnt[1], 1);
      tick(2);
      check("inv_idle_after", dout_o[1], 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
